axis_frame_fifo_keep: RTL and testbench
=======================================

// Module: axis_frame_fifo_keep
// PURPOSE
//  - Store-and-forward AXI-Stream frame FIFO with byte-enable (tkeep) support.
//  - A frame becomes visible at the output only after its tlast word is accepted and committed.
//  - Bad frames (tuser on tlast) and frames that overflow the buffer are discarded whole.
//  - Per-frame status pulses are provided.
//  - Sits between a MAC/parser source and a downstream consumer that must never see a partial or errored frame.
// PARAMETERS
//  ADDR_WIDTH     4  log2 of depth; memory holds 2**ADDR_WIDTH words
//  DATA_WIDTH     8  tdata width; must be a multiple of 8
//  KEEP_WIDTH     DATA_WIDTH/8  tkeep width
//  DROP_WHEN_FULL 1  1: in_tready is always 1 and overflowing frames are dropped; 0: backpressure on full
//  DROP_BAD_FRAME 1  1: a frame with in_tuser=1 on its tlast word is discarded; 0: in_tuser is ignored
// PORTS
//  clk             in   1           rising-edge clock
//  rst_n           in   1           asynchronous active-low reset
//  in_tdata        in   DATA_WIDTH  input data
//  in_tkeep        in   KEEP_WIDTH  input byte enables
//  in_tvalid       in   1           input valid
//  in_tready       out  1           input ready
//  in_tlast        in   1           input end of frame
//  in_tuser        in   1           input bad-frame flag, sampled only with tlast
//  out_tdata       out  DATA_WIDTH  output data
//  out_tkeep       out  KEEP_WIDTH  output byte enables
//  out_tvalid      out  1           output valid
//  out_tready      in   1           output ready
//  out_tlast       out  1           output end of frame
//  overflow        out  1           1-cycle pulse: frame dropped because the buffer was full
//  bad_frame       out  1           1-cycle pulse: frame dropped because of tuser
//  good_frame      out  1           1-cycle pulse: frame committed
//  frame_count     out  ADDR_WIDTH+1  committed, unread frames (present only with the macro)
// BEHAVIOUR
//  - Reset
//    - Asserting rst_n=0 clears wr_ptr, wr_ptr_cur and rd_ptr, drop state, out_tvalid, all status pulses and frame_count to 0.
//    - out_tdata/out_tkeep/out_tlast reset to 0.
//    - A frame that was partially written or partially read when reset hit is lost.
//  - Storage
//    - Each memory word holds {tlast, tkeep, tdata}.
//    - Pointers are ADDR_WIDTH+1 bits and wrap modulo 2**(ADDR_WIDTH+1).
//    - Full is defined as MSBs differing while the low bits are equal.
//  - Write acceptance
//    - A word is accepted when in_tvalid & in_tready.
//    - in_tready = DROP_WHEN_FULL ? 1 : ~full_cur | drop.
//  - Write path
//    - Each accepted word is written at wr_ptr_cur, then wr_ptr_cur increments.
//    - Committed pointer wr_ptr moves only on tlast.
//  - Commit (tlast accepted, not dropping, buffer not full)
//    - If DROP_BAD_FRAME & in_tuser: wr_ptr_cur<=wr_ptr and bad_frame is pulsed.
//    - Otherwise: wr_ptr<=wr_ptr_cur+1 and good_frame is pulsed.
//  - Overflow
//    - Triggered when a word is accepted while full_cur (wr_ptr_cur-rd_ptr==depth).
//    - With DROP_WHEN_FULL=0, also triggered when the frame alone fills the whole memory (full_cur & wr_ptr==rd_ptr).
//    - On overflow, enter drop state and discard words up to and including tlast.
//    - On that tlast: wr_ptr_cur<=wr_ptr, drop clears, overflow is pulsed.
//    - A frame whose tlast word arrives in the same cycle as full_cur is also dropped.
//  - Drop FSM: IDLE/STORE -> DROP on overflow; DROP -> STORE on the accepted tlast. In DROP, in_tuser is ignored and only overflow is pulsed.
//  - Read pipeline
//    - One output register stage.
//    - When (out_tready | ~out_tvalid): out_tvalid<=~empty, where empty is wr_ptr==rd_ptr using the committed pointer.
//    - If ~empty, the output register loads mem[rd_ptr] and rd_ptr increments.
//    - out_* stay stable while out_tvalid & ~out_tready.
//  - Latency: tlast is accepted at edge N, out_tvalid for the frame's first word rises at edge N+2 when the output is idle.
//    - Throughput is one word per cycle in each direction.
//  - Simultaneous events: commit and read in the same cycle are both honoured. Status pulses are mutually exclusive and each asserts for exactly one cycle.
// CONFIGURATION
//  - AXIS_FRAME_FIFO_COUNT_EN defined:
//    - frame_count increments on good_frame and decrements when an output word with out_tlast is transferred (out_tvalid & out_tready).
//    - When both happen in the same cycle, frame_count is unchanged.
//  - Not defined: frame_count port and its logic are absent. All other behaviour is identical.
// TESTING
//  - Single frame: 3 words, tkeep=1 on the last word, no tuser, ADDR_WIDTH=4 -> good_frame pulses at the tlast edge.
//    - Output words appear from tlast edge+2 with the same data and tkeep.
//  - Bad frame: 4 words, tuser=1 on tlast, DROP_BAD_FRAME=1 -> bad_frame pulses, out_tvalid stays 0.
//    - A following good 2-word frame is output intact.
//  - Overflow: DROP_WHEN_FULL=1, depth 16, 20-word frame -> overflow pulses on its tlast and nothing is output.
//    - The next 5-word frame passes.
//  - Backpressure: out_tready=0 for 10 cycles mid-frame -> out_* hold. DROP_WHEN_FULL=0 with 16 words stored -> in_tready=0 until a read.
//  - Concurrency: commit at the same edge as a read of the final word of a previous frame -> no word lost or duplicated.
//    - frame_count (macro on) unchanged.
//  - Reset: rst_n low mid-write and mid-read -> out_tvalid=0 asynchronously; after release a new 2-word frame passes cleanly.

Source files
------------

// File: rtl/axis_frame_fifo_keep_if.sv
// AXI-Stream bundle used on both sides of axis_frame_fifo_keep.
// The master drives data/valid/last/user and the slave returns ready.
interface axis_frame_fifo_keep_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_fifo_keep.sv
// Store-and-forward AXI-Stream frame FIFO with tkeep; bad or overflowing frames are dropped whole.
// Optional frame_count output is built when AXIS_FRAME_FIFO_COUNT_EN is defined.
module axis_frame_fifo_keep #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int DROP_WHEN_FULL = 1,
    parameter int DROP_BAD_FRAME = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axis_frame_fifo_keep_if.slave  in_axis,
    axis_frame_fifo_keep_if.master out_axis,
    output logic                   overflow,
    output logic                   bad_frame,
    output logic                   good_frame
`ifdef AXIS_FRAME_FIFO_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]    frame_count
`endif
);

    localparam int  DEPTH       = 1 << ADDR_WIDTH;
    localparam int  WORD_W      = 1 + KEEP_WIDTH + DATA_WIDTH;
    localparam bit  BACKPRESSURE = (DROP_WHEN_FULL == 0);
    localparam bit  BAD_DROP_EN  = (DROP_BAD_FRAME != 0);

    typedef logic [ADDR_WIDTH:0] ptr_t;
    typedef logic [WORD_W-1:0]   word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STORE,
        ST_DROP
    } state_e;

    word_t  mem_q [DEPTH];

    state_e state_q, state_d;
    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   wr_ptr_cur_q, wr_ptr_cur_d;
    ptr_t   wr_ptr_vis_q, wr_ptr_vis_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    logic   out_tvalid_q, out_tvalid_d;
    word_t  out_word_q, out_word_d;
    logic   overflow_q, overflow_d;
    logic   bad_frame_q, bad_frame_d;
    logic   good_frame_q, good_frame_d;

    logic   drop;
    logic   full_cur;
    logic   frame_fills_mem;
    logic   in_ready;
    logic   accept;
    logic   store_word;
    logic   commit;
    logic   commit_bad;
    logic   commit_good;
    logic   ovf_start;
    logic   ovf_end;
    logic   empty;
    logic   out_load;

    assign full_cur = (wr_ptr_cur_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                      (wr_ptr_cur_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign frame_fills_mem = full_cur && (wr_ptr_q == rd_ptr_q);

    assign in_ready   = BACKPRESSURE ? (~full_cur | drop) : 1'b1;
    assign accept     = in_axis.tvalid & in_ready;
    assign store_word = accept & ~drop & ~full_cur;
    assign commit     = store_word & in_axis.tlast;
    assign commit_bad  = commit & BAD_DROP_EN & in_axis.tuser;
    assign commit_good = commit & ~commit_bad;

    // A frame that alone fills the memory can never commit under backpressure, so drop it.
    assign ovf_start = ~drop & ((accept & full_cur) | (BACKPRESSURE & frame_fills_mem));
    assign ovf_end   = accept & in_axis.tlast & (drop | full_cur);

    // Reads see committed words one cycle after the commit.
    assign empty    = (wr_ptr_vis_q == rd_ptr_q);
    assign out_load = out_axis.tready | ~out_tvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_STORE: begin
                if (ovf_start && !(accept && in_axis.tlast)) begin
                    state_d = ST_DROP;
                end else if (accept) begin
                    state_d = ST_STORE;
                end
            end
            ST_DROP: begin
                if (accept && in_axis.tlast) begin
                    state_d = ST_STORE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        drop         = (state_q == ST_DROP);
        overflow_d   = ovf_end;
        bad_frame_d  = commit_bad;
        good_frame_d = commit_good;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        wr_ptr_cur_d = wr_ptr_cur_q;
        wr_ptr_vis_d = wr_ptr_q;
        if (commit_bad) begin
            wr_ptr_cur_d = wr_ptr_q;
        end else if (commit_good) begin
            wr_ptr_cur_d = wr_ptr_cur_q + ptr_t'(1);
            wr_ptr_d     = wr_ptr_cur_q + ptr_t'(1);
        end else if (store_word) begin
            wr_ptr_cur_d = wr_ptr_cur_q + ptr_t'(1);
        end
        if (ovf_end) begin
            wr_ptr_cur_d = wr_ptr_q;
        end
    end

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        out_tvalid_d = out_tvalid_q;
        out_word_d   = out_word_q;
        if (out_load) begin
            out_tvalid_d = ~empty;
            if (!empty) begin
                out_word_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
                rd_ptr_d   = rd_ptr_q + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store_word) begin
            mem_q[wr_ptr_cur_q[ADDR_WIDTH-1:0]] <= {in_axis.tlast, in_axis.tkeep, in_axis.tdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            wr_ptr_cur_q <= '0;
            wr_ptr_vis_q <= '0;
            rd_ptr_q     <= '0;
            out_tvalid_q <= 1'b0;
            out_word_q   <= '0;
            overflow_q   <= 1'b0;
            bad_frame_q  <= 1'b0;
            good_frame_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_ptr_cur_q <= wr_ptr_cur_d;
            wr_ptr_vis_q <= wr_ptr_vis_d;
            rd_ptr_q     <= rd_ptr_d;
            out_tvalid_q <= out_tvalid_d;
            out_word_q   <= out_word_d;
            overflow_q   <= overflow_d;
            bad_frame_q  <= bad_frame_d;
            good_frame_q <= good_frame_d;
        end
    end

`ifdef AXIS_FRAME_FIFO_COUNT_EN
    ptr_t frame_count_q, frame_count_d;
    logic out_last_xfer;

    assign out_last_xfer = out_tvalid_q & out_axis.tready & out_word_q[WORD_W-1];

    always_comb begin
        frame_count_d = frame_count_q;
        if (good_frame_d && !out_last_xfer) begin
            frame_count_d = frame_count_q + ptr_t'(1);
        end else if (!good_frame_d && out_last_xfer) begin
            frame_count_d = frame_count_q - ptr_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

    assign in_axis.tready  = in_ready;
    assign out_axis.tvalid = out_tvalid_q;
    assign out_axis.tlast  = out_word_q[WORD_W-1];
    assign out_axis.tkeep  = out_word_q[WORD_W-2 -: KEEP_WIDTH];
    assign out_axis.tdata  = out_word_q[DATA_WIDTH-1:0];
    assign out_axis.tuser  = 1'b0;
    assign overflow        = overflow_q;
    assign bad_frame       = bad_frame_q;
    assign good_frame      = good_frame_q;

endmodule

// File: tb/tb_axis_frame_fifo_keep.sv
// Scoreboard bench for axis_frame_fifo_keep: random frames against a frame-level queue model,
// plus directed overflow, bad-frame, hold, concurrency, reset and backpressure scenarios.
module tb_axis_frame_fifo_keep;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
    } beat_t;

    logic clk;
    logic rst_n;

    axis_frame_fifo_keep_if #(.DATA_WIDTH(16)) in_if ();
    axis_frame_fifo_keep_if #(.DATA_WIDTH(16)) out_if ();
    axis_frame_fifo_keep_if #(.DATA_WIDTH(8))  bp_in ();
    axis_frame_fifo_keep_if #(.DATA_WIDTH(8))  bp_out ();

    logic overflow, bad_frame, good_frame;
    logic bp_overflow, bp_bad_frame, bp_good_frame;
`ifdef AXIS_FRAME_FIFO_COUNT_EN
    logic [4:0] frame_count, bp_frame_count;
`endif

    axis_frame_fifo_keep #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DROP_WHEN_FULL(1), .DROP_BAD_FRAME(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_axis(in_if), .out_axis(out_if),
        .overflow(overflow), .bad_frame(bad_frame), .good_frame(good_frame)
`ifdef AXIS_FRAME_FIFO_COUNT_EN
        , .frame_count(frame_count)
`endif
    );

    axis_frame_fifo_keep #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DROP_WHEN_FULL(0), .DROP_BAD_FRAME(1)) u_bp (
        .clk(clk), .rst_n(rst_n), .in_axis(bp_in), .out_axis(bp_out),
        .overflow(bp_overflow), .bad_frame(bp_bad_frame), .good_frame(bp_good_frame)
`ifdef AXIS_FRAME_FIFO_COUNT_EN
        , .frame_count(bp_frame_count)
`endif
    );

    int    n_checks = 0;
    int    n_errors = 0;
    int    pushed_words = 0;
    int    popped_words = 0;
    int    exp_good = 0, exp_bad = 0, exp_ovf = 0;
    int    seen_good = 0, seen_bad = 0, seen_ovf = 0;
    int    ready_mode = 2;
    beat_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_checks++;
        n_errors++;
        $display("[TB] FAIL %s: wait budget expired", name);
    endtask

    // Output-side ready pattern: 0 always ready, 1 random, 2 stalled.
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_if.tready = 1'b1;
            1:       out_if.tready = ($urandom % 4) != 0;
            default: out_if.tready = 1'b0;
        endcase
    end

    always begin
        @(negedge clk);
        if (rst_n) begin
            if (good_frame) seen_good++;
            if (bad_frame)  seen_bad++;
            if (overflow)   seen_ovf++;
            if (out_if.tvalid && out_if.tready) begin
                if (exp_q.size() == 0) begin
                    timeoutFail("out_beat_unexpected");
                end else begin
                    checkOutput("out_beat", {out_if.tdata, out_if.tkeep, out_if.tlast}, exp_q.pop_front());
                    popped_words++;
                end
            end
        end
    end

    // Sends one frame starting at posedge+1 and returns at posedge+1 after the tlast edge.
    task automatic applyStimulus(input int len, input bit bad, input bit gaps);
        beat_t frame[$];
        bit    ovf;
        beat_t b;
        ovf = (pushed_words - popped_words + len) > DEPTH;
        for (int i = 0; i < len; i++) begin
            b.data = 16'($urandom);
            b.keep = 2'($urandom_range(1, 3));
            b.last = (i == len - 1);
            frame.push_back(b);
            in_if.tdata  = b.data;
            in_if.tkeep  = b.keep;
            in_if.tlast  = b.last;
            in_if.tuser  = b.last ? bad : 1'($urandom);
            in_if.tvalid = 1'b1;
            @(posedge clk);
            #1;
            if (gaps && !b.last && ($urandom % 4 == 0)) begin
                in_if.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        in_if.tuser  = 1'b0;
        checkOutput("overflow_pulse", overflow, ovf);
        checkOutput("bad_frame_pulse", bad_frame, !ovf && bad);
        checkOutput("good_frame_pulse", good_frame, !ovf && !bad);
        if (ovf) begin
            exp_ovf++;
        end else if (bad) begin
            exp_bad++;
        end else begin
            exp_good++;
            pushed_words += len;
            foreach (frame[i]) exp_q.push_back(frame[i]);
        end
    endtask

    task automatic waitSpace(input int len);
        int cnt = 0;
        while ((pushed_words - popped_words + len) > DEPTH && cnt < 3000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 3000) timeoutFail("wait_space");
    endtask

    task automatic waitDrain();
        int cnt = 0;
        while ((exp_q.size() != 0 || out_if.tvalid) && cnt < 3000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 3000) timeoutFail("wait_drain");
    endtask

    task automatic bpSend(input logic [7:0] data, input logic last);
        int cnt = 0;
        bp_in.tdata  = data;
        bp_in.tkeep  = 1'b1;
        bp_in.tlast  = last;
        bp_in.tvalid = 1'b1;
        @(negedge clk);
        while (!bp_in.tready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) timeoutFail("bp_send");
        @(posedge clk);
        #1;
        bp_in.tvalid = 1'b0;
    endtask

    initial begin
        logic [7:0] bp_exp[$];
        int         bp_got;
        int         cnt;
        bit         c_acc;

        rst_n = 1'b0;
        in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tkeep = '0; in_if.tlast = 1'b0; in_if.tuser = 1'b0;
        out_if.tready = 1'b0;
        bp_in.tvalid = 1'b0; bp_in.tdata = '0; bp_in.tkeep = '0; bp_in.tlast = 1'b0; bp_in.tuser = 1'b0;
        bp_out.tready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checkOutput("reset_out_tvalid", out_if.tvalid, 0);
        checkOutput("reset_pulses", {overflow, bad_frame, good_frame}, 0);
        checkOutput("reset_out_tdata", {out_if.tdata, out_if.tkeep, out_if.tlast}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_in_tready", in_if.tready, 1);
`ifdef AXIS_FRAME_FIFO_COUNT_EN
        checkOutput("reset_frame_count", frame_count, 0);
`endif

        $display("[TB] directed single, bad and overflow frames");
        ready_mode = 0;
        applyStimulus(3, 1'b0, 1'b1);
        waitDrain();
        applyStimulus(4, 1'b1, 1'b1);
        applyStimulus(2, 1'b0, 1'b1);
        waitDrain();
        applyStimulus(20, 1'b0, 1'b1);
        applyStimulus(5, 1'b0, 1'b1);
        waitDrain();
        applyStimulus(16, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(17, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(20, 1'b1, 1'b1);
        waitDrain();

        $display("[TB] random frames with random output ready");
        ready_mode = 1;
        for (int f = 0; f < 30; f++) begin
            int len;
            len = $urandom_range(1, 8);
            waitSpace(len);
            applyStimulus(len, ($urandom % 5) == 0, 1'b1);
        end
        ready_mode = 0;
        waitDrain();

        $display("[TB] commit alongside read of previous frame's last word");
        applyStimulus(3, 1'b0, 1'b0);
        applyStimulus(5, 1'b0, 1'b0);
`ifdef AXIS_FRAME_FIFO_COUNT_EN
        checkOutput("frame_count_concurrent", frame_count, 1);
`endif
        waitDrain();

        $display("[TB] output stall holds the presented word");
        ready_mode = 2;
        @(posedge clk);
        #1;
        applyStimulus(4, 1'b0, 1'b0);
        cnt = 0;
        while (!out_if.tvalid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("hold_valid", out_if.tvalid, 1);
            checkOutput("hold_beat", {out_if.tdata, out_if.tkeep, out_if.tlast}, exp_q[0]);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
        waitDrain();

        $display("[TB] reset mid-read and mid-write");
        ready_mode = 2;
        @(posedge clk);
        #1;
        applyStimulus(3, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
`ifdef AXIS_FRAME_FIFO_COUNT_EN
        checkOutput("frame_count_pending", frame_count, 1);
`endif
        in_if.tdata = 16'h1234; in_if.tkeep = 2'b11; in_if.tlast = 1'b0; in_if.tvalid = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out_tvalid", out_if.tvalid, 0);
        in_if.tvalid = 1'b0;
        exp_q.delete();
        pushed_words = 0;
        popped_words = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        applyStimulus(2, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] backpressure instance fills and stalls input");
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            bp_exp.push_back(8'(8'h10 + i));
            bpSend(8'(8'h10 + i), i == 7);
        end
        for (int i = 0; i < 9; i++) begin
            bp_exp.push_back(8'(8'h40 + i));
            bpSend(8'(8'h40 + i), i == 8);
        end
        bp_in.tdata = 8'hC0; bp_in.tkeep = 1'b1; bp_in.tlast = 1'b1; bp_in.tvalid = 1'b1;
        bp_exp.push_back(8'hC0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_in_tready_low", bp_in.tready, 0);
        end
        checkOutput("bp_out_first_word", {bp_out.tvalid, bp_out.tdata}, {1'b1, 8'h10});
        @(posedge clk);
        #1;
        bp_out.tready = 1'b1;
        bp_got = 0;
        c_acc = 1'b0;
        for (int cyc = 0; cyc < 200 && bp_got < 18; cyc++) begin
            @(negedge clk);
            if (bp_in.tvalid && bp_in.tready) c_acc = 1'b1;
            if (bp_out.tvalid && bp_out.tready) begin
                checkOutput("bp_out_word", bp_out.tdata, bp_exp.pop_front());
                bp_got++;
            end
            @(posedge clk);
            #1;
            if (c_acc) bp_in.tvalid = 1'b0;
        end
        checkOutput("bp_word_count", bp_got, 18);

        checkOutput("good_frame_count", seen_good, exp_good);
        checkOutput("bad_frame_count", seen_bad, exp_bad);
        checkOutput("overflow_count", seen_ovf, exp_ovf);
`ifdef AXIS_FRAME_FIFO_COUNT_EN
        checkOutput("frame_count_final", frame_count, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
